// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA square-drawing arbiter.
// Holds the screen bounds, default square size, colour width, the FSM
// state encoding and the round-robin winner selection helper.
package vga_draw_arbiter_pkg;

    localparam int XSCREEN  = 160;
    localparam int YSCREEN  = 120;
    localparam int XDIM_DEF = 10;
    localparam int YDIM_DEF = 10;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Round-robin pick over up to four requesters. The search starts at ptr
    // and ascends with wrap at n. Result is {found, index}.
    // Offsets are walked from high to low so the smallest offset wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int         n);
        logic [2:0] res;
        int         idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx]) begin
                    res = {1'b1, 2'(idx)};
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_scan.sv
// square_scan: row-major pixel scan counter for one square.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset
//   clear_i   synchronous clear of both counters
//   enable_i  advance one pixel this cycle
//   xc_o      column offset inside the square
//   yc_o      row offset inside the square
//   last_o    high while the scan sits on the final pixel
module square_scan
    import vga_draw_arbiter_pkg::*;
#(
    parameter int XDIM = XDIM_DEF,
    parameter int YDIM = YDIM_DEF,
    parameter int XW   = $clog2(XDIM + 1),
    parameter int YW   = $clog2(YDIM + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    output logic [XW-1:0] xc_o,
    output logic [YW-1:0] yc_o,
    output logic          last_o
);

    logic [XW-1:0] xc_q;
    logic [YW-1:0] yc_q;
    logic          x_end_s;
    logic          y_end_s;

    assign x_end_s = (xc_q == XW'(XDIM - 1));
    assign y_end_s = (yc_q == YW'(YDIM - 1));

    // Column/row counters; the row advances when the column wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            xc_q <= '0;
            yc_q <= '0;
        end else if (enable_i) begin
            if (x_end_s) begin
                xc_q <= '0;
                yc_q <= y_end_s ? '0 : yc_q + YW'(1);
            end else begin
                xc_q <= xc_q + XW'(1);
            end
        end else begin
            xc_q <= xc_q;
            yc_q <= yc_q;
        end
    end

    assign xc_o   = xc_q;
    assign yc_o   = yc_q;
    assign last_o = x_end_s && y_end_s;

endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin arbiter that lets N_REQ clients fill a
// XDIM x YDIM square each on a shared VGA pixel port, clipping pixels that
// fall off the visible screen.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i                 per-requester draw request (held until done)
//   req_x_i/req_y_i       per-requester top-left corner (8 / 7 bits each)
//   req_colour_i          per-requester fill colour (3 bits each)
//   hold_i                stall: freezes the scan while high
//   grant_o               one-hot, requester being served
//   done_o                one-cycle completion pulse for the served requester
//   busy_o                high whenever the FSM is not idle
//   x_o, y_o, colour_o    pixel to the VGA adapter (zero when not plotting)
//   plot_o                pixel write strobe
// All pixel-side outputs are registered, so they trail the FSM by one cycle.
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int XDIM    = XDIM_DEF,
    parameter int YDIM    = YDIM_DEF,
    parameter int XSCR    = XSCREEN,
    parameter int YSCR    = YSCREEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [8*N_REQ-1:0]        req_x_i,
    input  logic [7*N_REQ-1:0]        req_y_i,
    input  logic [COLOUR_W*N_REQ-1:0] req_colour_i,
    input  logic                      hold_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      busy_o,
    output logic [7:0]                x_o,
    output logic [6:0]                y_o,
    output logic [COLOUR_W-1:0]       colour_o,
    output logic                      plot_o
);

    localparam int XW = $clog2(XDIM + 1);
    localparam int YW = $clog2(YDIM + 1);

    state_e                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            win_q, win_d;
    logic [7:0]            x0_q, x0_d;
    logic [6:0]            y0_q, y0_d;
    logic [COLOUR_W-1:0]   col_q, col_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic                  plot_q, plot_d;
    logic [7:0]            x_q, x_d;
    logic [6:0]            y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;

    logic [3:0]            req_ext_s;
    logic [2:0]            pick_s;
    logic [1:0]            pick_idx_s;
    logic                  scan_clear_s;
    logic                  scan_en_s;
    logic [XW-1:0]         xc_s;
    logic [YW-1:0]         yc_s;
    logic                  last_s;
    logic [8:0]            sum_x_s;
    logic [7:0]            sum_y_s;
    logic                  clip_s;

    square_scan #(.XDIM(XDIM), .YDIM(YDIM), .XW(XW), .YW(YW)) u_scan (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (scan_clear_s),
        .enable_i (scan_en_s),
        .xc_o     (xc_s),
        .yc_o     (yc_s),
        .last_o   (last_s)
    );

    // Widen the request vector to the helper's fixed four-lane form.
    always_comb begin
        req_ext_s = 4'b0000;
        req_ext_s[N_REQ-1:0] = req_i;
    end

    assign pick_s     = rr_pick(req_ext_s, ptr_q, N_REQ);
    assign pick_idx_s = pick_s[1:0];

    // Sums are one bit wider than the coordinates so the clip test cannot wrap.
    assign sum_x_s = {1'b0, x0_q} + 9'(xc_s);
    assign sum_y_s = {1'b0, y0_q} + 8'(yc_s);
    assign clip_s  = (sum_x_s >= 9'(XSCR)) || (sum_y_s >= 8'(YSCR));

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            win_q    <= 2'd0;
            x0_q     <= 8'd0;
            y0_q     <= 7'd0;
            col_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            plot_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            col_q    <= col_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) state_d = ST_DRAW;
                else           state_d = ST_IDLE;
            end
            ST_DRAW: begin
                if (!hold_i && last_s) state_d = ST_DONE;
                else                   state_d = ST_DRAW;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and latch logic: arbitration in IDLE, pixel generation in DRAW,
    // completion and pointer advance in DONE.
    always_comb begin
        ptr_d        = ptr_q;
        win_d        = win_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        col_d        = col_q;
        grant_d      = grant_q;
        done_d       = '0;
        plot_d       = 1'b0;
        x_d          = 8'd0;
        y_d          = 7'd0;
        colour_d     = '0;
        scan_clear_s = 1'b0;
        scan_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                scan_clear_s = 1'b1;
                if (pick_s[2]) begin
                    win_d = pick_idx_s;
                    x0_d  = req_x_i[int'(pick_idx_s)*8 +: 8];
                    y0_d  = req_y_i[int'(pick_idx_s)*7 +: 7];
                    col_d = req_colour_i[int'(pick_idx_s)*COLOUR_W +: COLOUR_W];
                    for (int i = 0; i < N_REQ; i++) begin
                        grant_d[i] = (pick_idx_s == 2'(i));
                    end
                end else begin
                    grant_d = '0;
                end
            end
            ST_DRAW: begin
                if (!hold_i) begin
                    // A clipped pixel still spends its scan cycle.
                    scan_en_s = 1'b1;
                    if (!clip_s) begin
                        plot_d   = 1'b1;
                        x_d      = sum_x_s[7:0];
                        y_d      = sum_y_s[6:0];
                        colour_d = col_q;
                    end else begin
                        plot_d = 1'b0;
                    end
                end else begin
                    scan_en_s = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                ptr_d   = (win_q == 2'(N_REQ - 1)) ? 2'd0 : win_q + 2'd1;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign grant_o  = grant_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign plot_o   = plot_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: the driver plans each batch of
// fills with a reference model (round-robin order, pixel lists with
// clipping) and a monitor consumes plot/done/grant events against it.
module tb_vga_draw_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_x;
    logic [7*N-1:0]  req_y;
    logic [3*N-1:0]  req_colour;
    logic            hold;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    done_o;
    logic            busy_o;
    logic [7:0]      x_o;
    logic [6:0]      y_o;
    logic [2:0]      colour_o;
    logic            plot_o;

    vga_draw_arbiter #(.N_REQ(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_x_i      (req_x),
        .req_y_i      (req_y),
        .req_colour_i (req_colour),
        .hold_i       (hold),
        .grant_o      (grant_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .colour_o     (colour_o),
        .plot_o       (plot_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int m_ptr = 0;
    logic [N-1:0]  grant_prev = '0;
    logic [17:0]   exp_pix[$];
    logic [N-1:0]  exp_done[$];
    logic [N-1:0]  exp_grant[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: every pixel of the square in row-major order,
    // dropping the ones that fall outside the 160x120 screen.
    task automatic model_fill(input int r);
        int x0, y0, c;
        x0 = int'(req_x[8*r +: 8]);
        y0 = int'(req_y[7*r +: 7]);
        c  = int'(req_colour[3*r +: 3]);
        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 10; xx++)
                if (x0 + xx < 160 && y0 + yy < 120)
                    exp_pix.push_back({8'(x0 + xx), 7'(y0 + yy), 3'(c)});
        exp_done.push_back(N'(1) << r);
        exp_grant.push_back(N'(1) << r);
    endtask

    // Plan nf fills from the pending mask in round-robin order.
    task automatic model_plan(input logic [N-1:0] mask, input bit keep, input int nf);
        logic [N-1:0] pend;
        int w;
        pend = mask;
        for (int k = 0; k < nf; k++) begin
            w = -1;
            for (int off = N - 1; off >= 0; off--)
                if (pend[(m_ptr + off) % N]) w = (m_ptr + off) % N;
            if (w >= 0) begin
                model_fill(w);
                m_ptr = (w + 1) % N;
                if (!keep) pend[w] = 1'b0;
            end
        end
    endtask

    task automatic set_coords(input int r, input int xv, input int yv, input int cv);
        req_x[8*r +: 8]      = 8'(xv);
        req_y[7*r +: 7]      = 7'(yv);
        req_colour[3*r +: 3] = 3'(cv);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_plot", 32'(plot_o), 0);
        chk("rst_xyc", 32'({x_o, y_o, colour_o}), 0);
        rst = 1'b0;
        exp_pix.delete(); exp_done.delete(); exp_grant.delete();
        m_ptr = 0;
    endtask

    // Monitor: consumes DUT events against the scoreboard queues.
    always @(negedge clk) begin
        if (plot_o) begin
            plot_cnt++;
            if (exp_pix.size() == 0) chk("plot_unexpected", 1, 0);
            else chk("pixel", 32'({x_o, y_o, colour_o}), 32'(exp_pix.pop_front()));
        end
        if (done_o != '0) begin
            done_cnt++;
            if (exp_done.size() == 0) chk("done_unexpected", 32'(done_o), 0);
            else chk("done", 32'(done_o), 32'(exp_done.pop_front()));
        end
        if (grant_o != '0 && grant_prev == '0) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 32'(grant_o), 0);
            else chk("grant", 32'(grant_o), 32'(exp_grant.pop_front()));
        end
        chk("grant_onehot", 32'($countones(grant_o) <= 1), 1);
        if (!busy_o && !plot_o) chk("idle_xyc_zero", 32'({x_o, y_o, colour_o}), 0);
        grant_prev = grant_o;
    end

    // One fill with an optional stall and a mid-fill change of req_x.
    task automatic lat_fill(input int r, input int xv, input int yv, input int cv,
                            input int hl, input int newx, input int nplots);
        int t0, t1, n, p0;
        set_coords(r, xv, yv, cv);
        model_plan(N'(1) << r, 1'b0, 1);
        p0 = plot_cnt;
        req[r] = 1'b1;
        n = 0;
        while (grant_o == '0 && n < 50) begin @(posedge clk); #1; n++; end
        t0 = cyc;
        repeat (30) @(posedge clk);
        #1;
        req_x[8*r +: 8] = 8'(newx);
        if (hl > 0) begin
            hold = 1'b1;
            repeat (hl) @(posedge clk);
            #1;
            hold = 1'b0;
        end
        n = 0;
        while (done_o == '0 && n < 300) begin @(posedge clk); #1; n++; end
        t1 = cyc;
        req = '0;
        chk("latency", 32'(t1 - t0), 32'(101 + hl));
        repeat (2) @(posedge clk);
        #1;
        chk("fill_plots", 32'(plot_cnt - p0), 32'(nplots));
        chk("pix_drain", 32'(exp_pix.size()), 0);
    endtask

    task automatic do_batch(input logic [N-1:0] mask, input bit keep, input int nf,
                            input bit rnd_coords, input bit rnd_hold, input bit mutate,
                            input int exp_plots);
        int n, ndone, p0;
        if (rnd_coords)
            for (int r = 0; r < N; r++)
                set_coords(r, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
        model_plan(mask, keep, nf);
        p0 = plot_cnt;
        req = mask;
        ndone = 0; n = 0;
        while (ndone < nf && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (mutate && grant_o != '0 && $urandom_range(0, 7) == 0)
                for (int r = 0; r < N; r++)
                    if (grant_o[r])
                        set_coords(r, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
            if (done_o != '0) begin
                ndone++;
                if (!keep) req = req & ~done_o;
                else if (ndone == nf) req = '0;
            end
        end
        hold = 1'b0;
        req = '0;
        chk("batch_done_count", 32'(ndone), 32'(nf));
        repeat (3) @(posedge clk);
        #1;
        chk("pix_drain", 32'(exp_pix.size()), 0);
        if (exp_plots >= 0) chk("plot_count", 32'(plot_cnt - p0), 32'(exp_plots));
    endtask

    task automatic reset_abort();
        int n, p0, d0;
        set_coords(0, 10, 10, 4);
        model_plan(3'b001, 1'b0, 1);
        p0 = plot_cnt;
        req = 3'b001;
        n = 0;
        while (plot_cnt - p0 < 50 && n < 300) begin @(posedge clk); #1; n++; end
        rst = 1'b1; req = '0;
        @(posedge clk);
        #1;
        chk("abort_plot", 32'(plot_o), 0);
        chk("abort_grant", 32'(grant_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        rst = 1'b0;
        exp_pix.delete(); exp_done.delete(); exp_grant.delete();
        m_ptr = 0;
        d0 = done_cnt;
        repeat (120) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        do_batch(3'b010, 1'b0, 1, 1'b1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        logic [N-1:0] m;
        rst = 1'b1; req = '0; hold = 1'b0;
        req_x = '0; req_y = '0; req_colour = '0;
        do_reset();
        lat_fill(0, 39, 59, 2, 0, 39, 100);
        do_reset();
        do_batch(3'b111, 1'b1, 4, 1'b1, 1'b0, 1'b0, -1);
        set_coords(1, 155, 115, 6);
        do_batch(3'b010, 1'b0, 1, 1'b0, 1'b0, 1'b0, 25);
        lat_fill(0, 20, 30, 5, 7, 90, 100);
        reset_abort();
        for (int i = 0; i < 12; i++) begin
            m = N'($urandom_range(1, 7));
            do_batch(m, 1'b0, $countones(m), 1'b1, 1'b1, 1'b1, -1);
        end
        for (int i = 0; i < 3; i++) begin
            m = N'($urandom_range(1, 7));
            do_batch(m, 1'b1, $urandom_range(2, 5), 1'b1, 1'b1, 1'b0, -1);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of draw requesters (2..4).
REQ-002 Parameter XDIM, default 10, square width in pixels.
REQ-003 Parameter YDIM, default 10, square height in pixels.
REQ-004 Parameter XSCREEN, default 160, and YSCREEN, default 120, are the visible screen bounds.
REQ-005 Clock  input  1  single clock; all logic is on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 req  input  N_REQ  per-requester draw request, held high until its done pulse.
REQ-008 req_x  input  8*N_REQ  per-requester square top-left X; requester i uses bits [8i+7:8i].
REQ-009 req_y  input  7*N_REQ  per-requester square top-left Y; requester i uses bits [7i+6:7i].
REQ-010 req_colour  input  3*N_REQ  per-requester fill colour; requester i uses bits [3i+2:3i].
REQ-011 hold  input  1  stall; while high, pixel scanning freezes.
REQ-012 grant  output  N_REQ  one-hot, registered; identifies the requester being served.
REQ-013 done  output  N_REQ  one-cycle pulse on the served requester's bit at fill completion.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 x  output  8  pixel X to the VGA adapter.
REQ-016 y  output  7  pixel Y to the VGA adapter.
REQ-017 colour  output  3  pixel colour to the VGA adapter.
REQ-018 plot  output  1  pixel write strobe to the VGA adapter.

Function
REQ-019 The state machine has three states: IDLE, DRAW and DONE.
REQ-020 IDLE, when any req bit is high: select the winner round-robin, starting at pointer ptr and ascending with wrap; latch its x, y and colour; set grant; clear xc and yc; go to DRAW.
REQ-021 IDLE with req all zero: remain in IDLE; grant and plot stay 0.
REQ-022 DRAW, hold low: x=x0+xc, y=y0+yc, colour=latched colour; xc increments; at xc=XDIM-1, xc clears and yc increments.
REQ-023 DRAW, hold high: xc and yc freeze; plot=0.
REQ-024 In DRAW with hold low, plot=1 unless the pixel is clipped.
REQ-025 Clipping: a pixel is clipped when x0+xc >= XSCREEN or y0+yc >= YSCREEN.
REQ-026 Clipping comparisons use 9-bit and 8-bit sums, so no wrap-around is possible.
REQ-027 A clipped pixel still consumes its scan cycle.
REQ-028 DRAW exits to DONE after the unstalled cycle with xc=XDIM-1 and yc=YDIM-1.
REQ-029 DONE lasts one cycle: done[winner]=1, plot=0, grant clears, ptr=(winner+1) mod N_REQ, next state IDLE.
REQ-030 Latency: an unstalled fill takes 1 IDLE cycle + XDIM*YDIM DRAW cycles + 1 DONE cycle (102 cycles at 10x10).
REQ-031 Each hold-high cycle in DRAW adds exactly one cycle to the fill.
REQ-032 Changes to req, req_x, req_y or req_colour during DRAW or DONE do not affect the fill in progress.
REQ-033 A requester that keeps req high after done is re-arbitrated in the next IDLE cycle.
REQ-034 Every requester with req held high is granted within N_REQ fills.
REQ-035 x, y and colour read 0 whenever plot=0 outside DRAW.

Reset
REQ-036 While Reset is high, on the next edge: state=IDLE, ptr=0, xc=yc=0, latched registers cleared.
REQ-037 While Reset is high, on the next edge: grant=0, done=0, busy=0, plot=0, x=0, y=0, colour=0.
REQ-038 A reset asserted mid-DRAW aborts the fill with no done pulse.
REQ-039 Reset has priority over all other inputs.

Structure
REQ-040 The shared package holds XSCREEN, YSCREEN, the default XDIM and YDIM, the colour width (3) and the state encoding.
REQ-041 The xc/yc scan with its last-pixel flag is one sub-module, square_scan (inputs: clear, enable; outputs: xc, yc, last).
REQ-042 Arbitration and output muxing stay in vga_draw_arbiter.

Verification
REQ-043 Reset, then req=001, x=39, y=59, colour=3'b010 -> plot for 100 cycles covering x 39..48, y 59..68 row-major; done[0] pulses 101 cycles after DRAW entry.
REQ-044 req=111 held continuously -> grant order 001, 010, 100, 001; each done is one cycle; no two grants are ever active together.
REQ-045 req[1] with x=155, y=115 -> 100 scan cycles; plot=1 only for x 155..159, y 115..119 (25 pixels); done still pulses.
REQ-046 hold high for 7 cycles mid-DRAW -> plot=0 during the stall; xc/yc unchanged; done delayed by exactly 7 cycles.
REQ-047 Reset pulsed at pixel 50 of a fill -> next cycle plot=0, grant=0, busy=0; no done; next req=010 is granted normally.
REQ-048 req_x changed from 20 to 90 mid-DRAW -> remaining pixels stay based at x=20.
